uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte channel between NUM_REQ requesters, for example the periodic report generator and a debug/event message source.
- Grants whole messages, from the first byte through the byte flagged last, so messages never interleave on the serial line.
- Uses round-robin fairness across messages and a stall watchdog so a hung requester cannot lock the line.
- Sits between message sources and the UART TX serializer inside the UART MVP top.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- STALL_CYCLES, 4096: idle cycles allowed mid-message before forced release; 0 disables the watchdog.
- GW, derived $clog2(NUM_REQ): width of grant_id; localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high.
- tx_valid  out  1  byte offered to the serializer.
- tx_data  out  8  byte to the serializer.
- tx_ready  in  1  serializer can accept a byte; transfer occurs when tx_valid and tx_ready are both high.
- grant_active  out  1  a requester currently owns the line.
- grant_id  out  GW  index of the owner; holds the last owner while idle.
- abort_pulse  out  1  one-cycle pulse when the watchdog revokes a grant.
- stat_msgs  out  16*NUM_REQ  completed-message counters; see Optional Feature.

Behaviour:
- Reset values: tx_valid=0, req_ready=0, grant_active=0, grant_id=0, abort_pulse=0, stat_msgs=0, state=IDLE, stall_cnt=0. The round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-message: everything returns to the reset values immediately. The in-flight message is truncated with no further bytes. A serializer shift already in progress is not the arbiter's concern.
- IDLE state:
  - All outputs except grant_id and stat_msgs are 0.
  - If any req_valid is high, choose the first requester with req_valid high, scanning from last_grant+1 upward with wrap modulo NUM_REQ.
  - Register grant_id to that index, set grant_active=1, go to LOCK.
  - Arbitration costs exactly 1 cycle; no byte moves in the IDLE cycle.
- LOCK state, with owner g = grant_id:
  - tx_valid = req_valid[g] and tx_data = req_data[g], driven combinationally from the registered grant.
  - req_ready[g] = tx_ready; req_ready of every other requester = 0.
  - No bubble between consecutive bytes of one message: back-to-back transfers are allowed every cycle that tx_ready is high.
  - On a transfer with req_last[g]=1: last_grant<=g, grant_active<=0, next state IDLE. The next grant can be issued one cycle later.
- Stall watchdog (LOCK only):
  - stall_cnt clears on every transfer and increments each cycle with req_valid[g]=0.
  - A cycle with req_valid[g]=1 but tx_ready=0 is serializer backpressure and does not count.
  - When stall_cnt reaches STALL_CYCLES (non-zero): abort_pulse=1 for one cycle, last_grant<=g, state IDLE. No byte transfers in the abort cycle, and the watchdog resets stall_cnt.
- Simultaneous events:
  - Requests arriving during LOCK wait their turn, and a requester that asserts req_valid mid-grant is not preempted.
  - A last-byte transfer and a watchdog expiry cannot coincide, because a transfer clears the counter.
- Single-byte messages: req_last is set on the first byte; the grant lasts exactly one transfer.
- A requester must hold req_valid and req_data stable until its byte is accepted. The arbiter does not check this.

Optional Feature:
- Macro: UART_TX_ARB_STATS_EN.
- Defined: stat_msgs[16i+15:16i] increments on each completed message (last-byte transfer) from requester i. Counters saturate at 16'hFFFF. Aborted messages are not counted.
- Undefined: the port still exists and is tied to 0; no counter flops are instantiated.

Test Plan:
- Fairness with competing requesters: NUM_REQ=2, both requesters present 3-byte messages "AB\n" and "xy\n" continuously; tx_ready always 1 -> serializer sees "AB\nxy\nAB\nxy\n". grant_id alternates 0,1,0,1, with exactly one idle cycle between messages.
- Message atomicity under backpressure: requester 1 asserts req_valid mid-transfer of requester 0's 5-byte message; tx_ready toggles 1-in-4 -> all 5 bytes of requester 0 go out contiguously before requester 1's first byte, and req_ready[1] stays 0 throughout.
- Watchdog expiry: STALL_CYCLES=8; requester 0 sends 2 bytes, then drops req_valid without last -> abort_pulse high exactly 8 cycles after the last transfer. The next cycle returns to IDLE, and pending requester 1 is granted next.
- Backpressure is not a stall: STALL_CYCLES=8; req_valid[0] held high with tx_ready=0 for 100 cycles -> no abort_pulse. The byte transfers when tx_ready rises.
- Reset mid-message: assert rst while grant_active=1 and tx_valid=1 -> tx_valid, req_ready and grant_active go 0 asynchronously. After release, requester 0 wins first arbitration.
- Statistics counters (UART_TX_ARB_STATS_EN defined): 3 complete messages from requester 1 plus one aborted -> stat_msgs[31:16]=3 and stat_msgs[15:0]=0. With the macro undefined -> stat_msgs=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX byte channel.
// Define UART_TX_ARB_STATS_EN to build the per-requester message counters.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int STALL_CYCLES = 4096,
    localparam int GW          = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  grant_active,
    output logic [GW-1:0]         grant_id,
    output logic                  abort_pulse,
    output logic [16*NUM_REQ-1:0] stat_msgs
);

    localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [SW-1:0] STALL_LIM = SW'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] w_pick;
    logic [GW:0]   w_idx;
    logic [SW-1:0] r_stall_cnt;
    logic          w_own_valid;
    logic          w_own_last;
    logic          w_xfer;
    logic          w_done;
    logic          w_abort;

    assign w_own_valid = req_valid[r_grant_id];
    assign w_own_last  = req_last[r_grant_id];
    assign w_xfer      = tx_valid & tx_ready;
    assign w_done      = w_xfer & w_own_last;

    // Scan downward so the nearest requester after last_grant wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (GW+1)'(NUM_REQ);
            end
            if (req_valid[w_idx[GW-1:0]]) begin
                w_pick = w_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        w_abort   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_next = LOCK;
                end
            end
            LOCK: begin
                if (STALL_CYCLES != 0 && !w_own_valid && r_stall_cnt == STALL_LIM) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    tx_valid              = w_own_valid;
                    tx_data               = req_data[{r_grant_id, 3'b000} +: 8];
                    req_ready[r_grant_id] = tx_ready;
                    if (w_own_valid && tx_ready && w_own_last) begin
                        w_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |req_valid) begin
                r_grant_id <= w_pick;
            end
            if (r_state == LOCK && (w_abort || w_done)) begin
                r_last_grant <= r_grant_id;
            end
            // Backpressure (valid held, tx_ready low) is not a stall.
            if (r_state != LOCK || w_xfer || w_abort) begin
                r_stall_cnt <= '0;
            end else if (!w_own_valid && STALL_CYCLES != 0) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign grant_active = (r_state == LOCK);
    assign grant_id     = r_grant_id;
    assign abort_pulse  = w_abort;

`ifdef UART_TX_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [15:0] r_cnt;
        logic        w_hit;
        assign w_hit = w_done && (r_grant_id == GW'(i));
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_hit && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign stat_msgs[16*i +: 16] = r_cnt;
    end
`else
    assign stat_msgs = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (NUM_REQ=2, STALL_CYCLES=8).
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int ST = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic            grant_active;
    logic [0:0]      grant_id;
    logic            abort_pulse;
    logic [16*N-1:0] stat_msgs;

    uart_tx_arbiter #(.NUM_REQ(N), .STALL_CYCLES(ST)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_active(grant_active), .grant_id(grant_id),
        .abort_pulse(abort_pulse), .stat_msgs(stat_msgs)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic l; } src_t;
    typedef struct packed { logic [7:0] d; logic id; } exp_t;

    src_t q0[$];
    src_t q1[$];
    exp_t exp_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   last_xfer = -1;
    int   abort_gap = -1;
    int   n_abort = 0;
    int   tx_mode = 0;
    logic [1:0] en = 2'b00;
    logic gap_chk = 1'b0;
    logic new_msg = 1'b1;
    logic r1_leak = 1'b0;
    logic prev_abort = 1'b0;
    logic post_abort_act = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        req_valid[0]  = en[0] && (q0.size() > 0);
        req_data[7:0] = (q0.size() > 0) ? q0[0].d : 8'h00;
        req_last[0]   = (q0.size() > 0) ? q0[0].l : 1'b0;
        req_valid[1]  = en[1] && (q1.size() > 0);
        req_data[15:8] = (q1.size() > 0) ? q1[0].d : 8'h00;
        req_last[1]   = (q1.size() > 0) ? q1[0].l : 1'b0;
        tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? (cyc_n % 4 == 0) : 1'b0;
    endtask

    task automatic push_msg(input int r, input string s, input bit last_on, input bit sb);
        src_t b;
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            b.d = s[i];
            b.l = last_on && (i == s.len() - 1);
            if (r == 0) q0.push_back(b);
            else q1.push_back(b);
            if (sb) begin
                e.d = s[i];
                e.id = 1'(r);
                exp_q.push_back(e);
            end
        end
        drive();
    endtask

    task automatic tick();
        logic [1:0] fire;
        logic [1:0] oh;
        exp_t e;
        @(negedge clk);
        fire = req_valid & req_ready;
        if (prev_abort) post_abort_act = grant_active;
        prev_abort = abort_pulse;
        if (abort_pulse) begin
            n_abort++;
            abort_gap = cyc_n - last_xfer;
        end
        if (grant_active && grant_id == 1'b0 && req_ready[1]) r1_leak = 1'b1;
        if (tx_valid && tx_ready) begin
            oh = '0;
            oh[grant_id] = 1'b1;
            chk("ready_owner", 32'(fire), 32'(oh));
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("tx_owner", 32'(grant_id), 32'(e.id));
            end
            if (gap_chk && new_msg && last_xfer >= 0) begin
                chk("idle_gap", 32'(cyc_n - last_xfer), 32'd2);
            end
            new_msg = req_last[grant_id];
            last_xfer = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (fire[0] && q0.size() > 0) void'(q0.pop_front());
        if (fire[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    initial begin
        rst = 1'b1;
        drive();
        repeat (3) tick();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_abort", 32'(abort_pulse), 32'd0);
        chk("rst_stat", stat_msgs, 32'd0);
        rst = 1'b0;

        // Fairness: alternating whole messages, one idle cycle between.
        en = 2'b11;
        gap_chk = 1'b1;
        last_xfer = -1;
        push_msg(0, "AB\n", 1, 1);
        push_msg(1, "xy\n", 1, 1);
        push_msg(0, "AB\n", 1, 1);
        push_msg(1, "xy\n", 1, 1);
        repeat (22) tick();
        chk("fair_drained", 32'(exp_q.size()), 32'd0);
        gap_chk = 1'b0;

        // Atomicity under 1-in-4 backpressure.
        en = 2'b01;
        tx_mode = 1;
        r1_leak = 1'b0;
        push_msg(0, "HELLO", 1, 1);
        push_msg(1, "z", 1, 1);
        repeat (3) tick();
        en = 2'b11;
        drive();
        repeat (40) tick();
        chk("atom_drained", 32'(exp_q.size()), 32'd0);
        chk("atom_r1_ready_low", 32'(r1_leak), 32'd0);

        // Watchdog expiry after two bytes without last.
        tx_mode = 0;
        n_abort = 0;
        abort_gap = -1;
        post_abort_act = 1'b1;
        push_msg(0, "PQ", 0, 1);
        push_msg(1, "k", 1, 1);
        repeat (20) tick();
        chk("wd_abort_count", 32'(n_abort), 32'd1);
        chk("wd_abort_gap", 32'(abort_gap), 32'(ST));
        chk("wd_idle_after", 32'(post_abort_act), 32'd0);
        chk("wd_drained", 32'(exp_q.size()), 32'd0);

        // Serializer backpressure for 100 cycles must not trip the watchdog.
        n_abort = 0;
        tx_mode = 2;
        push_msg(0, "m", 1, 1);
        repeat (100) tick();
        chk("bp_no_abort", 32'(n_abort), 32'd0);
        chk("bp_held", 32'(exp_q.size()), 32'd1);
        chk("bp_active", 32'(grant_active), 32'd1);
        tx_mode = 0;
        drive();
        repeat (3) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-message from requester 1; requester 0 must win afterwards.
        tx_mode = 2;
        en = 2'b10;
        push_msg(1, "RST", 1, 0);
        repeat (3) tick();
        chk("mid_pre_active", 32'(grant_active), 32'd1);
        chk("mid_pre_valid", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_active", 32'(grant_active), 32'd0);
        tick();
        q1.delete();
        rst = 1'b0;
        en = 2'b11;
        tx_mode = 0;
        push_msg(0, "a", 1, 1);
        push_msg(1, "b", 1, 1);
        repeat (8) tick();
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Statistics: three complete messages and one aborted from requester 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 2'b10;
        n_abort = 0;
        push_msg(1, "s1\n", 1, 1);
        push_msg(1, "s2\n", 1, 1);
        push_msg(1, "s3\n", 1, 1);
        repeat (16) tick();
        push_msg(1, "q", 0, 1);
        repeat (16) tick();
        chk("stat_abort_seen", 32'(n_abort), 32'd1);
        chk("stat_drained", 32'(exp_q.size()), 32'd0);
`ifdef UART_TX_ARB_STATS_EN
        chk("stat_r1", 32'(stat_msgs[31:16]), 32'd3);
        chk("stat_r0", 32'(stat_msgs[15:0]), 32'd0);
`else
        chk("stat_tied_zero", stat_msgs, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
